// File: rtl/muxn_pkg.sv
// Shared definitions for the muxn_rr_reg channel multiplexer:
// mode encodings, parameter limits and a small pointer helper.
package muxn_pkg;

  // Values of the mode input
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Supported parameter ranges
  localparam int N_MAX = 16;
  localparam int W_MAX = 64;

  // Next channel index after idx, wrapping at n back to 0
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    nxt = idx + 1;
    if (nxt >= n) begin
      nxt = 0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/muxn_rr_reg_rr_arb.sv
// Round-robin arbiter for muxn_rr_reg.
// Searches req starting at ptr and wrapping through N-1 back to 0.
// The first requester found wins. The ptr register itself lives in the parent.
module rr_arb #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          gnt_vld
);

  logic [SW:0]   pos_sum;
  logic [SW-1:0] pos_idx;
  logic          found;

  // Priority search in rotated order; gnt is only asserted when enabled
  always_comb begin
    gnt     = '0;
    idx     = '0;
    gnt_vld = 1'b0;
    found   = 1'b0;
    pos_sum = '0;
    pos_idx = '0;
    for (int k = 0; k < N; k++) begin
      pos_sum = {1'b0, ptr} + (SW+1)'(k);
      if (pos_sum >= (SW+1)'(N)) begin
        pos_sum = pos_sum - (SW+1)'(N);
      end
      pos_idx = pos_sum[SW-1:0];
      if (!found && req[pos_idx]) begin
        found = 1'b1;
        idx   = pos_idx;
      end
    end
    if (en && found) begin
      gnt_vld  = 1'b1;
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/muxn_rr_reg.sv
// Registered N-input, W-bit multiplexer with valid/ready on every channel.
// In fixed mode the channel is chosen by sel; in round-robin mode an
// arbiter picks among the valid channels starting at the rotating pointer.
// The chosen word is captured in an output register that can be refilled
// in the same cycle it is drained.
// Optional build macro: MUXN_PARITY_EN adds the out_par port (^out_data).
module muxn_rr_reg
  import muxn_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_ch
`ifdef MUXN_PARITY_EN
  ,
  output logic          out_par
`endif
);

  // Per-channel view of the packed input bus
  logic [W-1:0] ch_data [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_split
      assign ch_data[gi] = in_data[gi*W +: W];
    end
  endgenerate

  logic [W-1:0]  data_reg;
  logic          valid_reg;
  logic [SW-1:0] ch_reg;
  logic [SW-1:0] ptr_reg;
  logic [SW-1:0] ptr_next;

  logic          load;
  logic          sel_ok;
  logic          fix_req;
  logic          rr_en;
  logic [N-1:0]  arb_gnt;
  logic [SW-1:0] arb_idx;
  logic          arb_vld;

  logic          grant;
  logic [SW-1:0] gnt_idx;
  logic [N-1:0]  gnt_vec;

  // The register can accept a word when empty or being drained this cycle
  assign load = !valid_reg | out_ready;

  // sel beyond the channel count never grants (only reachable for non power-of-two N)
  assign sel_ok  = ({1'b0, sel} < (SW+1)'(N));
  assign fix_req = sel_ok & in_valid[sel];

  assign rr_en = load & (mode == MODE_RR);

  rr_arb #(
    .N (N)
  ) u_rr_arb (
    .req     (in_valid),
    .ptr     (ptr_reg),
    .en      (rr_en),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Select the grant source for the current mode
  always_comb begin
    grant   = 1'b0;
    gnt_idx = '0;
    gnt_vec = '0;
    if (mode == MODE_FIXED) begin
      if (load && fix_req) begin
        grant        = 1'b1;
        gnt_idx      = sel;
        gnt_vec[sel] = 1'b1;
      end
    end else begin
      grant   = arb_vld;
      gnt_idx = arb_idx;
      gnt_vec = arb_gnt;
    end
  end

  // Ready goes only to the granted channel and stays low throughout reset
  assign in_ready = rst ? gnt_vec : '0;

  assign ptr_next = SW'(wrap_inc(32'(gnt_idx), N));

  // Round-robin pointer moves past the winner only on round-robin grants
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= '0;
    end else if (grant && (mode == MODE_RR)) begin
      ptr_reg <= ptr_next;
    end
  end

  // Output register: load on grant, drop valid when drained with nothing new
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_reg  <= '0;
      ch_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (grant) begin
      data_reg  <= ch_data[gnt_idx];
      ch_reg    <= gnt_idx;
      valid_reg <= 1'b1;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_data  = data_reg;
  assign out_valid = valid_reg;
  assign out_ch    = ch_reg;

`ifdef MUXN_PARITY_EN
  logic par_reg;

  // Parity travels with the data word and changes only when a new word loads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_reg <= 1'b0;
    end else if (grant) begin
      par_reg <= ^ch_data[gnt_idx];
    end
  end

  assign out_par = par_reg;
`endif

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Directed bench for muxn_rr_reg with N=4, W=4: a table of vectors applied
// back to back, plus hand sequences for asynchronous reset and parity.
module tb_muxn_rr_reg;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int SW = 2;
  localparam int NV = 23;
  localparam logic [N*W-1:0] DATA = 16'h7531; // ch3=7 ch2=5 ch1=3 ch0=1

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_ch;
`ifdef MUXN_PARITY_EN
  logic          out_par;
`endif

  always #5 clk = ~clk;

  muxn_rr_reg #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
`ifdef MUXN_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  typedef struct packed {
    logic          mode;
    logic [SW-1:0] sel;
    logic [N-1:0]  valid;
    logic          ordy;
    logic [N-1:0]  exp_ir;
    logic          exp_ov;
    logic [W-1:0]  exp_od;
    logic [SW-1:0] exp_ch;
  } vec_t;

  vec_t vecs [NV];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic m, input logic [SW-1:0] s, input logic [N-1:0] v,
                              input logic r, input logic [N-1:0] ir, input logic ov,
                              input logic [W-1:0] od, input logic [SW-1:0] ch);
    vec_t t;
    t.mode = m; t.sel = s; t.valid = v; t.ordy = r;
    t.exp_ir = ir; t.exp_ov = ov; t.exp_od = od; t.exp_ch = ch;
    return t;
  endfunction

  task automatic drive(input logic m, input logic [SW-1:0] s, input logic [N*W-1:0] d,
                       input logic [N-1:0] v, input logic r);
    mode      = m;
    sel       = s;
    in_data   = d;
    in_valid  = v;
    out_ready = r;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [W-1:0] od,
                         input logic [SW-1:0] ch);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, " out_data"},  32'(out_data),  32'(od));
    chk({tag, " out_ch"},    32'(out_ch),    32'(ch));
  endtask

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              mode sel valid    rdy  in_ready  ov  od    ch
    vecs[0]  = mk(1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'h5, 2'd2);
    vecs[1]  = mk(1'b0, 2'd1, 4'b0100, 1'b1, 4'b0000, 1'b0, 4'h5, 2'd2);
    vecs[2]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
    vecs[3]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'h3, 2'd1);
    vecs[4]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'h5, 2'd2);
    vecs[5]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'h7, 2'd3);
    vecs[6]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
    vecs[7]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'h3, 2'd1);
    vecs[8]  = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd1);
    vecs[9]  = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd1);
    vecs[10] = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd1);
    vecs[11] = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd1);
    vecs[12] = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd1);
    vecs[13] = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'h5, 2'd2);
    vecs[14] = mk(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'h3, 2'd1);
    vecs[15] = mk(1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
    vecs[16] = mk(1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 4'h7, 2'd3);
    vecs[17] = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'h3, 2'd1);
    vecs[18] = mk(1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd1);
    vecs[19] = mk(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'h3, 2'd1);
    vecs[20] = mk(1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'h1, 2'd0);
    vecs[21] = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0);
    vecs[22] = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'h5, 2'd2);

    // Power-on reset with requests pending: nothing may be granted
    rst = 1'b0;
    drive(1'b1, 2'd0, DATA, 4'b1111, 1'b1);
    #1;
    chk_out("reset", 1'b0, 4'h0, 2'd0);
    chk("reset in_ready", 32'(in_ready), 32'h0);
`ifdef MUXN_PARITY_EN
    chk("reset out_par", 32'(out_par), 32'h0);
`endif
    in_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b1;

    // Table-driven sequence; each vector depends on the state left by the previous
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].mode, vecs[i].sel, DATA, vecs[i].valid, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_ch);
      $display("vec %0d mode=%0d sel=%0d valid=%b rdy=%0d -> in_ready=%b out_valid=%0d out_data=%h out_ch=%0d",
               i, vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].ordy,
               in_ready, out_valid, out_data, out_ch);
    end

    // Reset in the middle of a transfer, with word 4'hA in the register
    @(negedge clk);
    drive(1'b0, 2'd1, 16'h75A1, 4'b0010, 1'b1);
    #1;
    chk("mid load in_ready", 32'(in_ready), 32'h2);
    @(posedge clk);
    #1;
    chk_out("mid load", 1'b1, 4'hA, 2'd1);
    $display("mid-reset setup: out_valid=%0d out_data=%h out_ch=%0d", out_valid, out_data, out_ch);
    @(negedge clk);
    drive(1'b1, 2'd0, 16'h75A1, 4'b1111, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk_out("async reset", 1'b0, 4'h0, 2'd0);
    chk("async reset in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk_out("reset held", 1'b0, 4'h0, 2'd0);
    chk("reset held in_ready", 32'(in_ready), 32'h0);
    $display("reset held: in_ready=%b out_valid=%0d", in_ready, out_valid);

    // First edge after release grants channel 0 (pointer back at 0)
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post reset in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk_out("post reset", 1'b1, 4'h1, 2'd0);
    $display("post-reset grant: out_data=%h out_ch=%0d", out_data, out_ch);

`ifdef MUXN_PARITY_EN
    // Parity follows the granted word and holds when nothing is granted
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0007, 4'b0001, 1'b1);
    @(posedge clk);
    #1;
    chk("par 0111 out_data", 32'(out_data), 32'h7);
    chk("par 0111 out_par", 32'(out_par), 32'h1);
    $display("parity grant 7: out_par=%0d", out_par);
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0006, 4'b0001, 1'b1);
    @(posedge clk);
    #1;
    chk("par 0110 out_data", 32'(out_data), 32'h6);
    chk("par 0110 out_par", 32'(out_par), 32'h0);
    $display("parity grant 6: out_par=%0d", out_par);
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0007, 4'b0001, 1'b1);
    @(posedge clk);
    #1;
    chk("par regrant out_par", 32'(out_par), 32'h1);
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0006, 4'b0000, 1'b1);
    @(posedge clk);
    #1;
    chk("par hold out_valid", 32'(out_valid), 32'h0);
    chk("par hold out_par", 32'(out_par), 32'h1);
    $display("parity no grant: out_valid=%0d out_par=%0d", out_valid, out_par);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
